// File: rtl/mips_run_monitor.sv
// Run monitor for a MIPS core: lets the CPU run until it reaches END_PC or the cycle limit
// expires, then freezes it and streams a window of data memory out over a valid/ready port.
module mips_run_monitor #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter logic [31:0] END_PC     = 32'h9C,
  parameter int unsigned DUMP_BASE  = 50,
  parameter int unsigned DUMP_COUNT = 21,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              halt,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [9:0]        dump_index,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    StRun,
    StSettle,
    StDump,
    StDone,
    StTimeout
  } state_e;

  localparam logic [ADDR_W-1:0] EndPc      = ADDR_W'(END_PC);
  localparam logic [ADDR_W-1:0] BaseAddr   = ADDR_W'(DUMP_BASE);
  localparam logic [9:0]        LastIdx    = (DUMP_COUNT == 0) ? 10'd0 : 10'(DUMP_COUNT - 1);
  localparam logic [3:0]        SettleInit = 4'(SETTLE);
  localparam logic [31:0]       TimeoutAt  = 32'(MAX_CYCLES - 1);
  localparam bit                HasTimeout = (MAX_CYCLES != 0);
  localparam bit                HasDump    = (DUMP_COUNT != 0);
  localparam bit                HasSettle  = (SETTLE != 0);

  state_e              r_state;
  logic [3:0]          r_settle;
  logic [9:0]          r_idx;
  logic                r_halt;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_done;
  logic                r_timeout;
  logic [31:0]         r_cycle;

  logic                w_pc_hit;
  logic                w_limit;

  // pc_i only matters while the CPU is running
  assign w_pc_hit = (r_state == StRun) && (pc_i == EndPc);
  assign w_limit  = HasTimeout && (r_cycle == TimeoutAt);

  // Control FSM with all outputs registered; reset discards any dump in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StRun;
      r_settle  <= '0;
      r_idx     <= '0;
      r_halt    <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cycle   <= '0;
    end else begin
      case (r_state)
        StRun: begin
          // A PC match takes priority over the cycle limit
          if (w_pc_hit) begin
            r_halt <= 1'b1;
            if (HasSettle) begin
              r_state  <= StSettle;
              r_settle <= SettleInit;
            end else if (HasDump) begin
              r_state <= StDump;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else if (w_limit) begin
            r_state   <= StTimeout;
            r_timeout <= 1'b1;
            r_halt    <= 1'b1;
          end else if (r_cycle != 32'hFFFF_FFFF) begin
            r_cycle <= r_cycle + 32'd1;
          end
        end
        StSettle: begin
          if (r_settle == 4'd1) begin
            if (HasDump) begin
              r_state <= StDump;
            end else begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        StDump: begin
          // valid low means the word at the current index is being fetched this cycle
          if (!r_valid) begin
            r_data  <= dmem_rdata;
            r_valid <= 1'b1;
          end else if (dump_ready) begin
            r_valid <= 1'b0;
            if (r_idx == LastIdx) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + 10'd1;
            end
          end
        end
        StDone, StTimeout: begin
          // terminal until reset
        end
        default: r_state <= StRun;
      endcase
    end
  end

  assign halt        = r_halt;
  assign dmem_raddr  = BaseAddr + ADDR_W'(r_idx);
  assign dump_valid  = r_valid;
  assign dump_data   = r_data;
  assign dump_index  = r_idx;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle;

endmodule
